mmio_bridge: RTL and testbench

Single-outstanding memory-mapped I/O bridge between the core's load/store unit and the peripheral slots. It accepts one request over a valid/ready handshake and decodes the address to either the timer slot (single-cycle, `cen`/`wr` strobe) or a generic device slot (multi-cycle, with ready and a timeout). It then returns read data and an error flag over a valid/ready response channel. The timer sits directly downstream and consumes the `tmr_cen`/`tmr_wr` strobes this block produces.

---
 rtl/mmio_bridge_if.sv | 55 +++++
 rtl/mmio_bridge.sv | 165 ++++++++++++++++
 tb/tb_mmio_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bridge_if.sv
// -----------------------------------------------------------------------------
// mmio_bridge_if
// Bundles every bus signal around the MMIO bridge: the core-side request and
// response channels plus the timer slot and the generic device slot.
//   master : core / peripheral side (drives requests, resp_ready and slot
//            return data; observes everything the bridge drives)
//   slave  : the bridge itself
// Signals:
//   req_valid/req_ready/req_addr/req_wr/req_wdata    request channel
//   resp_valid/resp_ready/resp_rdata/resp_error      response channel
//   tmr_cen/tmr_wr/tmr_rdata/tmr_error               timer slot
//   dev_cen/dev_wr/dev_addr/dev_wdata/dev_rdata/
//   dev_ready/dev_error                              device slot
// -----------------------------------------------------------------------------
interface mmio_bridge_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_wr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  logic            tmr_cen;
  logic            tmr_wr;
  logic [XLEN-1:0] tmr_rdata;
  logic            tmr_error;

  logic            dev_cen;
  logic            dev_wr;
  logic [XLEN-1:0] dev_addr;
  logic [XLEN-1:0] dev_wdata;
  logic [XLEN-1:0] dev_rdata;
  logic            dev_ready;
  logic            dev_error;

  modport master (
    output req_valid, req_addr, req_wr, req_wdata, resp_ready,
           tmr_rdata, tmr_error, dev_rdata, dev_ready, dev_error,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           tmr_cen, tmr_wr, dev_cen, dev_wr, dev_addr, dev_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, resp_ready,
           tmr_rdata, tmr_error, dev_rdata, dev_ready, dev_error,
    output req_ready, resp_valid, resp_rdata, resp_error,
           tmr_cen, tmr_wr, dev_cen, dev_wr, dev_addr, dev_wdata
  );
endinterface

// File: rtl/mmio_bridge.sv
// -----------------------------------------------------------------------------
// mmio_bridge
// Single-outstanding bridge from the load/store unit to two peripheral slots.
// A request is latched in IDLE, decoded to the timer slot (one-cycle strobe),
// the device slot (multi-cycle with ready and timeout) or a miss (fault), and
// the result is returned on a valid/ready response channel.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; drops any in-flight transaction
//   bus  mmio_bridge_if.slave carrying request, response, timer and device
//        signals
// -----------------------------------------------------------------------------
module mmio_bridge #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] TMR_BASE = 64'h0200_BFF8,
  parameter logic [XLEN-1:0] TMR_MASK = 64'hFFFF_FFF8,
  parameter logic [XLEN-1:0] DEV_BASE = 64'h1000_0000,
  parameter logic [XLEN-1:0] DEV_MASK = 64'hFFFF_F000,
  parameter int              TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  mmio_bridge_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_wr;
  logic            r_tmr_hit;
  logic            r_dev_hit;
  logic [XLEN-1:0] r_rdata;
  logic            r_error;
  logic [CW-1:0]   r_cnt;

  logic            w_tmr_hit;
  logic            w_dev_hit;
  logic            w_accept;
  logic            w_cap;
  logic [XLEN-1:0] w_cap_rdata;
  logic            w_cap_error;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_dev_active;

  // Timer wins when both windows match the same address.
  assign w_tmr_hit = (bus.req_addr & TMR_MASK) == TMR_BASE;
  assign w_dev_hit = ((bus.req_addr & DEV_MASK) == DEV_BASE) && !w_tmr_hit;
  assign w_accept  = bus.req_valid && (r_state == ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_next      = r_state;
    w_cap       = 1'b0;
    w_cap_rdata = '0;
    w_cap_error = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_tmr_hit) begin
          // Stores return zero data; the timer's error still passes through.
          w_cap       = 1'b1;
          w_cap_rdata = r_wr ? '0 : bus.tmr_rdata;
          w_cap_error = bus.tmr_error;
          w_next      = ST_RESP;
        end else if (r_dev_hit) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_WAIT;
        end else begin
          w_cap       = 1'b1;
          w_cap_error = 1'b1;
          w_next      = ST_RESP;
        end
      end
      ST_WAIT: begin
        // Ready is checked first so a completion on the last allowed cycle
        // beats the timeout.
        if (bus.dev_ready) begin
          w_cap       = 1'b1;
          w_cap_rdata = r_wr ? '0 : bus.dev_rdata;
          w_cap_error = bus.dev_error;
          w_next      = ST_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // This cycle's increment would reach TIMEOUT: give up.
          w_cap       = 1'b1;
          w_cap_error = 1'b1;
          w_next      = ST_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_tmr_hit <= 1'b0;
      r_dev_hit <= 1'b0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_wr      <= bus.req_wr;
        r_tmr_hit <= w_tmr_hit;
        r_dev_hit <= w_dev_hit;
      end
      if (w_cap) begin
        r_rdata <= w_cap_rdata;
        r_error <= w_cap_error;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Outputs decode state and latches only; nothing here depends on req_*.
  assign w_dev_active = ((r_state == ST_ACCESS) && r_dev_hit) || (r_state == ST_WAIT);

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_error = r_error;

  assign bus.tmr_cen    = (r_state == ST_ACCESS) && r_tmr_hit;
  assign bus.tmr_wr     = (r_state == ST_ACCESS) && r_tmr_hit && r_wr;

  assign bus.dev_cen    = w_dev_active;
  assign bus.dev_wr     = w_dev_active && r_wr;
  assign bus.dev_addr   = w_dev_active ? r_addr  : '0;
  assign bus.dev_wdata  = w_dev_active ? r_wdata : '0;

endmodule

// File: tb/tb_mmio_bridge.sv
// -----------------------------------------------------------------------------
// tb_mmio_bridge
// Self-checking bench for mmio_bridge. Each transaction's expected response,
// latency and slot activity come from a transaction-level model of the
// address map and slot rules; directed cases are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_mmio_bridge;

  localparam int          XLEN     = 64;
  localparam int          TIMEOUT  = 16;
  localparam logic [63:0] TMR_BASE = 64'h0200_BFF8;
  localparam logic [63:0] TMR_MASK = 64'hFFFF_FFF8;
  localparam logic [63:0] DEV_BASE = 64'h1000_0000;
  localparam logic [63:0] DEV_MASK = 64'hFFFF_F000;
  localparam int          NEVER    = 1000;

  typedef enum logic [1:0] {K_TMR, K_DEV, K_MISS} kind_e;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mmio_bridge_if #(.XLEN(XLEN)) bus ();

  mmio_bridge #(
    .XLEN     (XLEN),
    .TMR_BASE (TMR_BASE),
    .TMR_MASK (TMR_MASK),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic kind_e classify(input logic [63:0] a);
    if ((a & TMR_MASK) == TMR_BASE) return K_TMR;
    if ((a & DEV_MASK) == DEV_BASE) return K_DEV;
    return K_MISS;
  endfunction

  // Runs one transaction; called and returns at a falling edge.
  // dly: device asserts ready on its (dly)th wait cycle (0-based).
  // hold: cycles the response is backpressured with a new request pending.
  task automatic run_txn(input string tag, input logic [63:0] addr, input logic wr,
                         input logic [63:0] wdata, input logic [63:0] t_rd,
                         input logic t_err, input int dly, input logic [63:0] d_rd,
                         input logic d_err, input int hold);
    kind_e       k;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_tc, exp_dc;
    int          cyc, lat, tc, dc, dev_bad, twr_bad;
    logic        seen;

    // Transaction-level expectations.
    k = classify(addr);
    case (k)
      K_TMR: begin
        exp_rdata = wr ? 64'd0 : t_rd; exp_err = t_err;
        exp_lat = 2; exp_tc = 1; exp_dc = 0;
      end
      K_DEV: begin
        exp_tc = 0;
        if (dly < TIMEOUT) begin
          exp_rdata = wr ? 64'd0 : d_rd; exp_err = d_err;
          exp_lat = 3 + dly; exp_dc = dly + 2;
        end else begin
          exp_rdata = 64'd0; exp_err = 1'b1;
          exp_lat = 2 + TIMEOUT; exp_dc = TIMEOUT + 1;
        end
      end
      default: begin
        exp_rdata = 64'd0; exp_err = 1'b1;
        exp_lat = 2; exp_tc = 0; exp_dc = 0;
      end
    endcase

    check({tag, " req_ready before"}, {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wr    = wr;
    bus.req_wdata = wdata;
    bus.tmr_rdata = t_rd;
    bus.tmr_error = t_err;
    bus.dev_rdata = d_rd;
    bus.dev_error = d_err;
    bus.dev_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus so only latched values can be correct.
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wr    = ~wr;
    bus.req_wdata = {$urandom, $urandom};

    cyc = 1; lat = 0; tc = 0; dc = 0; dev_bad = 0; twr_bad = 0; seen = 1'b0;
    while (!seen && cyc <= TIMEOUT + 8) begin
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        if (bus.tmr_cen) begin
          tc++;
          if (bus.tmr_wr !== wr) twr_bad++;
        end
        if (bus.dev_cen) begin
          dc++;
          if (bus.dev_addr !== addr || bus.dev_wdata !== wdata || bus.dev_wr !== wr)
            dev_bad++;
        end
        bus.dev_ready = (k == K_DEV) && (cyc == 2 + dly);
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    bus.dev_ready = 1'b0;

    check({tag, " resp seen"}, {63'd0, seen}, 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, " error"}, {63'd0, bus.resp_error}, {63'd0, exp_err});
    check({tag, " tmr_cen cycles"}, 64'(tc), 64'(exp_tc));
    check({tag, " tmr_wr value"}, 64'(twr_bad), 64'd0);
    check({tag, " dev_cen cycles"}, 64'(dc), 64'(exp_dc));
    check({tag, " dev bus stable"}, 64'(dev_bad), 64'd0);
    check({tag, " dev_cen in resp"}, {63'd0, bus.dev_cen}, 64'd0);

    if (!seen) begin
      // Recover from a stuck DUT so the remaining cases still run.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold valid"}, {63'd0, bus.resp_valid}, 64'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, " hold req_ready"}, {63'd0, bus.req_ready}, 64'd0);
    end

    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check({tag, " resp dropped"}, {63'd0, bus.resp_valid}, 64'd0);
    check({tag, " req_ready after"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    int          sel;
    int          spurious;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wr     = 1'b0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.tmr_rdata  = '0;
    bus.tmr_error  = 1'b0;
    bus.dev_rdata  = '0;
    bus.dev_ready  = 1'b0;
    bus.dev_error  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("reset resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("reset resp_rdata", bus.resp_rdata, 64'd0);
    check("reset resp_error", {63'd0, bus.resp_error}, 64'd0);
    check("reset tmr_cen", {63'd0, bus.tmr_cen}, 64'd0);
    check("reset dev_cen", {63'd0, bus.dev_cen}, 64'd0);
    check("reset dev_addr", bus.dev_addr, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the address map and slot rules.
    run_txn("tmr read", 64'h0200_BFF8, 1'b0, 64'd0, 64'h1234, 1'b0, 0, 64'd0, 1'b0, 0);
    run_txn("tmr write err", 64'h0200_BFF8, 1'b1, 64'h55, 64'hDEAD, 1'b1, 0, 64'd0, 1'b0, 0);
    run_txn("unmapped", 64'h8000_0000, 1'b0, 64'd0, 64'h77, 1'b0, 0, 64'h99, 1'b0, 0);
    run_txn("dev read", 64'h1000_0010, 1'b0, 64'd0, 64'd0, 1'b0, 5, 64'hAB, 1'b0, 0);
    run_txn("dev timeout", 64'h1000_0010, 1'b0, 64'd0, 64'd0, 1'b0, NEVER, 64'hAB, 1'b0, 0);
    run_txn("dev ready at limit", 64'h1000_0020, 1'b0, 64'd0, 64'd0, 1'b0, TIMEOUT - 1,
            64'hC0FFEE, 1'b0, 0);
    run_txn("dev ready past limit", 64'h1000_0020, 1'b0, 64'd0, 64'd0, 1'b0, TIMEOUT,
            64'hC0FFEE, 1'b0, 0);
    run_txn("dev write err", 64'h1000_0FF8, 1'b1, 64'h1122_3344, 64'd0, 1'b0, 0,
            64'hFFFF, 1'b1, 0);
    run_txn("backpressure", 64'h0200_BFF8, 1'b0, 64'd0, 64'h5A5A, 1'b0, 0, 64'd0, 1'b0, 10);
    // Issued immediately: the bridge must accept on the very next edge.
    run_txn("after backpressure", 64'h0200_BFF8, 1'b0, 64'd0, 64'hA5A5, 1'b0, 0, 64'd0,
            1'b0, 0);

    // Reset while the device is stalled in the wait phase.
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h1000_0010;
    bus.req_wr    = 1'b0;
    bus.dev_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("mid-wait dev_cen", {63'd0, bus.dev_cen}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst dev_cen", {63'd0, bus.dev_cen}, 64'd0);
    check("rst resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst dev_addr", bus.dev_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    spurious = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.dev_cen) spurious++;
    end
    bus.resp_ready = 1'b0;
    check("no response after reset", 64'(spurious), 64'd0);

    // Random traffic over all three targets.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0:       a = {$urandom, 32'h0200_BFF8 | ($urandom & 32'h7)};
        1:       a = {$urandom, 32'h1000_0000 | ($urandom & 32'hFFF)};
        default: a = {$urandom, $urandom};
      endcase
      run_txn($sformatf("rand%0d", n), a, 1'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom), $urandom_range(0, TIMEOUT + 2),
              {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls outside a bounded loop.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
